// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl
//   Multicycle signed MULT/DIV sequencer for the MIPS datapath. Owns the HI
//   and LO registers. A start pulse launches a DATA_W-cycle iteration. The
//   cycle after the last iteration shows a one-cycle done pulse, and hi/lo
//   already hold the new result in that cycle.
//
// Ports
//   clk        in   1       clock, rising edge
//   reset      in   1       synchronous, active-high; clears all state
//   mult_start in   1       1-cycle pulse: begin signed a*b
//   div_start  in   1       1-cycle pulse: begin signed a/b (mult_start wins)
//   a          in   DATA_W  multiplicand / dividend, sampled on the start edge
//   b          in   DATA_W  multiplier / divisor, sampled on the start edge
//   hi         out  DATA_W  product[2W-1:W] or remainder
//   lo         out  DATA_W  product[W-1:0] or quotient
//   busy       out  1       operation in flight (MULT, DIV or DONE)
//   done       out  1       1-cycle result pulse
//   div_zero   out  1       coincident with done when the divisor was zero
module mult_div_ctrl #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mult_start,
    input  logic              div_start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              div_zero
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam int unsigned ACC_W = 2 * DATA_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    // Shared working register.
    //   MULT: {A, Q, q_-1}.
    //   DIV:  {remainder, quotient, unused}.
    logic [ACC_W-1:0]  acc_q,   acc_d;
    logic [DATA_W-1:0] m_q,     m_d;     // multiplicand, or divisor magnitude
    logic [DATA_W-1:0] hi_q,    hi_d;
    logic [DATA_W-1:0] lo_q,    lo_d;
    logic              qneg_q,  qneg_d;  // quotient must be negated
    logic              rneg_q,  rneg_d;  // remainder must be negated
    logic              dz_q,    dz_d;

    logic [DATA_W-1:0] abs_a, abs_b;
    logic [DATA_W:0]   booth_sum;
    logic [ACC_W-1:0]  booth_next;
    logic [DATA_W:0]   div_shift, div_trial;
    logic [ACC_W-1:0]  div_next;
    logic [DATA_W-1:0] q_mag, r_mag;

    assign abs_a = a[DATA_W-1] ? -a : a;
    assign abs_b = b[DATA_W-1] ? -b : b;

    // The Booth add/subtract is done one bit wider than A, and the shift
    // takes its result from that wider sum. -2^(W-1) * -2^(W-1) would
    // otherwise overflow A on the final subtract.
    always_comb begin
        booth_sum = {acc_q[ACC_W-1], acc_q[ACC_W-1 -: DATA_W]};
        case (acc_q[1:0])
            2'b01:   booth_sum = booth_sum + {m_q[DATA_W-1], m_q};
            2'b10:   booth_sum = booth_sum - {m_q[DATA_W-1], m_q};
            default: booth_sum = booth_sum;
        endcase
        booth_next = {booth_sum, acc_q[DATA_W:1]};
    end

    // One restoring step: shift the quotient MSB into the remainder, then
    // subtract the divisor if it fits.
    always_comb begin
        div_shift = {acc_q[ACC_W-1 -: DATA_W], acc_q[DATA_W]};
        div_trial = div_shift - {1'b0, m_q};
        if (div_trial[DATA_W]) begin
            div_next = {div_shift[DATA_W-1:0], acc_q[DATA_W-1:1], 1'b0, 1'b0};
        end else begin
            div_next = {div_trial[DATA_W-1:0], acc_q[DATA_W-1:1], 1'b1, 1'b0};
        end
        q_mag = div_next[DATA_W:1];
        r_mag = div_next[ACC_W-1 -: DATA_W];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE: begin
                if (mult_start) begin
                    state_d = S_MULT;
                    cnt_d   = '0;
                    dz_d    = 1'b0;
                    acc_d   = {{DATA_W{1'b0}}, b, 1'b0};
                    m_d     = a;
                end else if (div_start) begin
                    cnt_d   = '0;
                    acc_d   = {{DATA_W{1'b0}}, abs_a, 1'b0};
                    m_d     = abs_b;
                    qneg_d  = a[DATA_W-1] ^ b[DATA_W-1];
                    rneg_d  = a[DATA_W-1];
                    if (b == '0) begin
                        state_d = S_DONE;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = S_DIV;
                        dz_d    = 1'b0;
                    end
                end
            end
            S_MULT: begin
                acc_d = booth_next;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    hi_d    = booth_next[ACC_W-1 -: DATA_W];
                    lo_d    = booth_next[DATA_W:1];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DIV: begin
                acc_d = div_next;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    hi_d    = rneg_q ? -r_mag : r_mag;
                    lo_d    = qneg_q ? -q_mag : q_mag;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign div_zero = (state_q == S_DONE) && dz_q;

endmodule
